fp16_div_vec_seq: RTL and testbench
===================================

Name: fp16_div_vec_seq

Overview:
- Upstream sequencer for the iterative FP16 divider (`FP16_div`) in the vector processor divide path.
- Accepts one vector of LANES FP16 dividend/divisor pairs with a start pulse.
- Issues each lane to the divider in turn over its input_valid/idle handshake and collects each quotient on output_update.
- Presents the assembled result vector with a one-cycle done pulse.

Parameters:
- LANES, 4, number of FP16 elements per vector (2..16).
- IDX_W, 2, lane index width; must equal clog2(LANES).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- vec_dividend  input  16*LANES  dividends, lane i at bits [16i+15:16i].
- vec_divisor  input  16*LANES  divisors, same packing.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse; result_vec valid from this cycle until the next accepted start.
- result_vec  output  16*LANES  quotients, same packing.
- div_input_valid  output  1  to divider input_valid; one-cycle pulse.
- div_dividend  output  16  to divider data_dividend.
- div_divisor  output  16  to divider data_divisor.
- div_idle  input  1  from divider idle.
- div_output_update  input  1  from divider output_update; one-cycle pulse.
- div_q  input  16  from divider data_q.

Behaviour:
Reset (async, rst=1):
- State goes to IDLE.
- busy, done, div_input_valid = 0.
- div_dividend, div_divisor, result_vec, lane index = 0.
- Reset mid-operation abandons the vector.
- A divider result arriving after reset release while in IDLE is ignored.

FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - start=1 registers both operand vectors, sets lane index to 0, busy=1, then goes to ISSUE.
  - start=0: no action.
- ISSUE:
  - Holds until div_idle=1.
  - In the cycle div_idle=1 is seen: drives div_dividend/div_divisor with the current lane operands, pulses div_input_valid for exactly that one cycle, then goes to WAIT.
  - div_dividend/div_divisor hold their value until the next issue.
- WAIT:
  - On div_output_update=1, writes div_q into result_vec at the current lane.
  - If this is the last lane (index = LANES-1), goes to DONE.
  - Otherwise increments the index and goes to ISSUE.
  - div_output_update seen in any state other than WAIT is ignored.
- DONE:
  - done=1 for one cycle, busy=0 in that cycle, then goes to IDLE.

Boundary rules:
- start while busy=1 (ISSUE/WAIT/DONE) is ignored, and the latched operands are not disturbed.
- start in the same cycle as done is ignored; it is accepted no earlier than the following IDLE cycle.
- Operands are captured at start; later changes to vec_* inputs have no effect.
- result_vec lanes not yet written in the current run keep their previous values until overwritten.
- No arithmetic is done here. Quotients are passed through bit-exact, including divider saturation codes (0x7fff/0xffff).

Latency per lane: 1 cycle for the ISSUE handshake (when div_idle is already 1), plus the divider latency D, plus 1 capture cycle. done follows the last capture by 1 cycle.

Optional Feature:
Macro: FP16_DIV_ZERO_BYPASS_EN

With the macro defined, in ISSUE:
- A lane whose divisor has bits[14:0]=0 is not sent to the divider.
- Its result is written directly as {dividend[15]^divisor[15], 15'h7fff}, matching the divider's saturation code.
- The FSM advances to the next lane (or DONE) in the same cycle, with no div_input_valid pulse.
- An extra output port dz_flags [LANES-1:0] sets bit i for each bypassed lane.
- dz_flags is cleared at start and at reset, and is valid with done.

Without the macro:
- All lanes are issued to the divider.
- The dz_flags port does not exist.

Test Plan:
- Reset, then start with LANES=4: dividends {5543,d543,35c8,32b3}, divisors {3e82,410f,16b8,0400}, real `FP16_div` attached -> done once; result_vec lanes {5276,d029,5ae2,6ab3}; exactly 4 div_input_valid pulses.
- Hold div_idle=0 for 20 cycles in ISSUE (stub divider) -> no div_input_valid pulse until div_idle=1; then exactly one pulse.
- Pulse start again at cycles 3 and 30 of an active run -> ignored; the operands and results of the first run are unchanged.
- Assert rst during WAIT of lane 2, then release, then issue a new start with lane0 d543/ffff -> all outputs 0 during reset; the new run completes with lane0=ffff.
- With FP16_DIV_ZERO_BYPASS_EN, lane1 divisor=8000 and dividend=5543 -> lane1=ffff, dz_flags=4'b0010, 3 div_input_valid pulses.
- Back-to-back: start in the first IDLE cycle after done -> accepted; busy rises the next cycle; the previous result_vec is held until overwritten.

Source files
------------

// File: rtl/fp16_div_vec_seq.sv
// fp16_div_vec_seq: feeds a vector of FP16 dividend/divisor pairs, one lane at a
// time, through the iterative FP16 divider and assembles the quotient vector.
// Optional feature macro: FP16_DIV_ZERO_BYPASS_EN. When defined, lanes whose
// divisor magnitude is zero skip the divider and get the saturation code
// directly, and the dz_flags port reports which lanes were bypassed.
module fp16_div_vec_seq #(
  parameter int LANES = 4,
  parameter int IDX_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [16*LANES-1:0]   vec_dividend,
  input  logic [16*LANES-1:0]   vec_divisor,
  output logic                  busy,
  output logic                  done,
  output logic [16*LANES-1:0]   result_vec,
  output logic                  div_input_valid,
  output logic [15:0]           div_dividend,
  output logic [15:0]           div_divisor,
  input  logic                  div_idle,
  input  logic                  div_output_update,
  input  logic [15:0]           div_q
`ifdef FP16_DIV_ZERO_BYPASS_EN
  ,
  output logic [LANES-1:0]      dz_flags
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(LANES - 1);

  state_t                state;
  logic [IDX_W-1:0]      idx;
  logic [16*LANES-1:0]   op_dividend;
  logic [16*LANES-1:0]   op_divisor;
  logic [IDX_W+3:0]      lane_off;
  logic [15:0]           cur_dvd;
  logic [15:0]           cur_dvs;
  logic                  last_lane;

`ifdef FP16_DIV_ZERO_BYPASS_EN
  // Divide-by-zero result: signed maximum, identical to the divider's own code.
  function automatic logic [15:0] sat_code(input logic sign);
    return {sign, 15'h7fff};
  endfunction
`endif

  assign lane_off  = {idx, 4'b0000};
  assign cur_dvd   = op_dividend[lane_off +: 16];
  assign cur_dvs   = op_divisor[lane_off +: 16];
  assign last_lane = (idx == LAST_LANE);

  // Operand capture: the vectors are latched only when a start is accepted.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      op_dividend <= vec_dividend;
      op_divisor  <= vec_divisor;
    end
  end

  // Lane sequencer FSM with registered handshake and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      idx             <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      div_input_valid <= 1'b0;
      div_dividend    <= '0;
      div_divisor     <= '0;
      result_vec      <= '0;
`ifdef FP16_DIV_ZERO_BYPASS_EN
      dz_flags        <= '0;
`endif
    end else begin
      div_input_valid <= 1'b0;
      done            <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            idx   <= '0;
            busy  <= 1'b1;
            state <= ISSUE;
`ifdef FP16_DIV_ZERO_BYPASS_EN
            dz_flags <= '0;
`endif
          end
        end
        ISSUE: begin
`ifdef FP16_DIV_ZERO_BYPASS_EN
          if (cur_dvs[14:0] == 15'd0) begin
            result_vec[lane_off +: 16] <= sat_code(cur_dvd[15] ^ cur_dvs[15]);
            dz_flags[idx]              <= 1'b1;
            if (last_lane) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              idx   <= idx + 1'b1;
              state <= ISSUE;
            end
          end else
`endif
          if (div_idle) begin
            div_dividend    <= cur_dvd;
            div_divisor     <= cur_dvs;
            div_input_valid <= 1'b1;
            state           <= WAIT;
          end
        end
        WAIT: begin
          if (div_output_update) begin
            result_vec[lane_off +: 16] <= div_q;
            if (last_lane) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              idx   <= idx + 1'b1;
              state <= ISSUE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_div_vec_seq.sv
// Bench for fp16_div_vec_seq: a behavioural divider stand-in with fixed latency,
// operand and result scoreboards, and a linear sequence of directed runs.
module tb_fp16_div_vec_seq;

  localparam int LANES = 4;
  localparam int DLAT  = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [16*LANES-1:0] vec_dividend = '0;
  logic [16*LANES-1:0] vec_divisor = '0;
  logic                busy;
  logic                done;
  logic [16*LANES-1:0] result_vec;
  logic                div_input_valid;
  logic [15:0]         div_dividend;
  logic [15:0]         div_divisor;
  logic                div_idle;
  logic                div_output_update = 1'b0;
  logic [15:0]         div_q = '0;
`ifdef FP16_DIV_ZERO_BYPASS_EN
  logic [LANES-1:0]    dz_flags;
`endif

  int total = 0;
  int bad = 0;
  int pulses = 0;
  int dones = 0;

  logic [31:0] exp_ops[$];
  logic [63:0] exp_res[$];
  logic [3:0]  exp_dz[$];

  logic        hold_idle = 1'b0;
  logic        s_busy = 1'b0;
  int          s_cnt = 0;
  logic [15:0] s_q = '0;

  fp16_div_vec_seq #(.LANES(LANES), .IDX_W(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .vec_dividend      (vec_dividend),
    .vec_divisor       (vec_divisor),
    .busy              (busy),
    .done              (done),
    .result_vec        (result_vec),
    .div_input_valid   (div_input_valid),
    .div_dividend      (div_dividend),
    .div_divisor       (div_divisor),
    .div_idle          (div_idle),
    .div_output_update (div_output_update),
    .div_q             (div_q)
`ifdef FP16_DIV_ZERO_BYPASS_EN
    ,
    .dz_flags          (dz_flags)
`endif
  );

  always #5 clk = ~clk;

  // Divider reference: known quotients for the directed pairs, a fixed
  // scramble for any other pair.
  function automatic logic [15:0] model_q(input logic [15:0] a, input logic [15:0] b);
    case ({a, b})
      32'h5543_3e82: return 16'h5276;
      32'hd543_410f: return 16'hd029;
      32'h35c8_16b8: return 16'h5ae2;
      32'h32b3_0400: return 16'h6ab3;
      32'hd543_ffff: return 16'hffff;
      default:       return {a[7:0] ^ b[15:8], a[15:8] + b[7:0]};
    endcase
  endfunction

  // Divider stand-in; deliberately not reset by rst so it can finish in-flight work.
  assign div_idle = !s_busy && !hold_idle;
  always @(posedge clk) begin
    div_output_update <= 1'b0;
    if (s_busy) begin
      if (s_cnt == 0) begin
        div_output_update <= 1'b1;
        div_q             <= s_q;
        s_busy            <= 1'b0;
      end else begin
        s_cnt <= s_cnt - 1;
      end
    end else if (div_input_valid) begin
      s_busy <= 1'b1;
      s_cnt  <= DLAT - 2;
      s_q    <= model_q(div_dividend, div_divisor);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Push expectations for a vector and drive it on the inputs.
  task automatic prep(input logic [63:0] dvd, input logic [63:0] dvs);
    logic [63:0] r;
    logic [3:0]  dz;
    logic [15:0] a;
    logic [15:0] b;
    r  = '0;
    dz = '0;
    for (int i = 0; i < LANES; i++) begin
      a = dvd[16*i +: 16];
      b = dvs[16*i +: 16];
`ifdef FP16_DIV_ZERO_BYPASS_EN
      if (b[14:0] == 15'd0) begin
        r[16*i +: 16] = {a[15] ^ b[15], 15'h7fff};
        dz[i] = 1'b1;
      end else
`endif
      begin
        exp_ops.push_back({a, b});
        r[16*i +: 16] = model_q(a, b);
      end
    end
    exp_res.push_back(r);
    exp_dz.push_back(dz);
    vec_dividend = dvd;
    vec_divisor  = dvs;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (done !== 1'b1 && n < limit) begin
      tick(1);
      n++;
    end
    chk("done_seen", 64'(done), 64'(1));
  endtask

  // Scoreboard monitor: operands at each issue, results at each done.
  logic [31:0] op_e;
  logic [63:0] res_e;
  logic [3:0]  dz_e;
  always @(negedge clk) begin
    if (!rst) begin
      if (div_input_valid) begin
        pulses++;
        chk("op_avail", 64'(exp_ops.size() != 0), 64'(1));
        if (exp_ops.size() != 0) begin
          op_e = exp_ops.pop_front();
          chk("issue_operands", {32'd0, div_dividend, div_divisor}, {32'd0, op_e});
        end
      end
      if (done) begin
        dones++;
        chk("res_avail", 64'(exp_res.size() != 0), 64'(1));
        if (exp_res.size() != 0) begin
          res_e = exp_res.pop_front();
          dz_e  = exp_dz.pop_front();
          chk("result_vec", result_vec, res_e);
          chk("busy_at_done", 64'(busy), 64'(0));
`ifdef FP16_DIV_ZERO_BYPASS_EN
          chk("dz_flags", 64'(dz_flags), 64'(dz_e));
`endif
        end
      end
    end
  end

  localparam logic [63:0] DVD_A = 64'h32b3_35c8_d543_5543;
  localparam logic [63:0] DVS_A = 64'h0400_16b8_410f_3e82;

  int p0;
  int d0;

  initial begin
    // Reset state
    tick(3);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_valid", 64'(div_input_valid), 64'(0));
    chk("rst_dividend", 64'(div_dividend), 64'(0));
    chk("rst_divisor", 64'(div_divisor), 64'(0));
    chk("rst_result", result_vec, 64'(0));
    rst = 1'b0;
    tick(2);

    // Run A: directed vector, spurious starts at cycles 3 and 30, inputs changed after capture
    prep(DVD_A, DVS_A);
    pulse_start();
    chk("busy_after_start", 64'(busy), 64'(1));
    vec_dividend = 64'h1111_2222_3333_4444;
    vec_divisor  = 64'h5555_6666_7777_0000;
    tick(1);
    pulse_start();
    tick(26);
    pulse_start();
    wait_done(400);
    chk("runA_pulses", 64'(pulses), 64'(4));
    chk("runA_dones", 64'(dones), 64'(1));
    chk("runA_lanes", result_vec, 64'h6ab3_5ae2_d029_5276);

    // Run B: start held through the done cycle, then accepted; divider held not-idle
    p0 = pulses;
    prep(64'h4a00_c400_3c00_4800, 64'h3c00_4000_4200_bc00);
    hold_idle = 1'b1;
    start = 1'b1;
    tick(1);
    chk("start_in_done_ignored", 64'(busy), 64'(0));
    tick(1);
    start = 1'b0;
    chk("b2b_busy", 64'(busy), 64'(1));
    chk("b2b_result_held", result_vec, 64'h6ab3_5ae2_d029_5276);
    tick(20);
    chk("hold_no_pulse", 64'(pulses - p0), 64'(0));
    hold_idle = 1'b0;
    tick(3);
    chk("hold_one_pulse", 64'(pulses - p0), 64'(1));
    wait_done(400);
    chk("runB_pulses", 64'(pulses - p0), 64'(4));
    tick(1);

    // Run C: reset during WAIT of lane 2
    p0 = pulses;
    d0 = dones;
    prep(DVD_A, DVS_A);
    pulse_start();
    for (int n = 0; n < 400 && (pulses - p0) < 3; n++) tick(1);
    chk("runC_reached_lane2", 64'(pulses - p0), 64'(3));
    tick(2);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    chk("midrst_valid", 64'(div_input_valid), 64'(0));
    chk("midrst_dividend", 64'(div_dividend), 64'(0));
    chk("midrst_divisor", 64'(div_divisor), 64'(0));
    chk("midrst_result", result_vec, 64'(0));
    tick(2);
    rst = 1'b0;
    exp_ops.delete();
    exp_res.delete();
    exp_dz.delete();
    tick(12);
    chk("late_update_ignored", result_vec, 64'(0));
    chk("idle_after_rst", 64'(busy), 64'(0));
    chk("no_done_after_rst", 64'(dones - d0), 64'(0));

    // Run D: fresh vector after reset, lane 0 saturates
    p0 = pulses;
    prep(64'h32b3_35c8_d543_d543, 64'h0400_16b8_410f_ffff);
    pulse_start();
    wait_done(400);
    chk("runD_lane0", 64'(result_vec[15:0]), 64'(16'hffff));
    chk("runD_pulses", 64'(pulses - p0), 64'(4));
    tick(2);

`ifdef FP16_DIV_ZERO_BYPASS_EN
    // Run E: lane 1 divisor is negative zero and bypasses the divider
    p0 = pulses;
    prep(64'h32b3_35c8_5543_5543, 64'h0400_16b8_8000_3e82);
    pulse_start();
    wait_done(400);
    chk("bypass_lane1", 64'(result_vec[31:16]), 64'(16'hffff));
    chk("bypass_flags", 64'(dz_flags), 64'(4'b0010));
    chk("bypass_pulses", 64'(pulses - p0), 64'(3));
    tick(2);
`endif

    chk("queues_drained", 64'(exp_ops.size() + exp_res.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
